adder_frame_sequencer: RTL and testbench

- Controller between the byte-level UART core (rx_status/rx_d_out, tx_en/tx_d_in/tx_status) and the bank of adder implementations under test.
- Receives a 9-byte command frame: 1 header byte, then 8 operand bytes.
- Selects the adder and launches it. Waits for completion with a watchdog, then streams the 32-bit sum back MSB first.
- Replaces ad-hoc byte counting with an explicit FSM, inter-byte timeout and error flags.

---
 rtl/adder_seq_pkg.sv | 23 ++
 rtl/uart_fall_det.sv | 18 +
 rtl/adder_frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_adder_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder frame sequencer.
// ADDER_SEQ_CARRY_BYTE_EN adds a fifth TX byte that carries the adder carry-out.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OPS   = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_ADD = 3'd3,
    TX       = 3'd4
  } state_t;

  localparam int OP_BYTES = 8;

`ifdef ADDER_SEQ_CARRY_BYTE_EN
  localparam int TX_BYTES = 5;
`else
  localparam int TX_BYTES = 4;
`endif

  localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;

endpackage

// File: rtl/uart_fall_det.sv
// Registered falling-edge detector for a UART busy/status line.
module uart_fall_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_fall
);

  logic r_sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sig_q <= 1'b0;
    else        r_sig_q <= i_sig;
  end

  assign o_fall = r_sig_q & ~i_sig;

endmodule

// File: rtl/adder_frame_sequencer.sv
// Frame sequencer: header + 8 operand bytes in, launches the selected adder, streams the sum out MSB first.
// Define ADDER_SEQ_CARRY_BYTE_EN to append {7'b0, cout} as a fifth TX byte.
module adder_frame_sequencer
  import adder_seq_pkg::*;
#(
  parameter int         RX_GAP_CYC  = 1_000_000,
  parameter int         ADD_MAX_CYC = 64,
  parameter logic [3:0] HDR_MAGIC   = HDR_MAGIC_DEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rx_status,
  input  logic [7:0]  rx_d_out,
  input  logic        tx_status,
  output logic        tx_en,
  output logic [7:0]  tx_d_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [1:0]  adder_sel,
  output logic        add_start,
  input  logic        add_done,
  input  logic [31:0] sum,
  input  logic        cout,
  input  logic        err_clr,
  output logic        busy,
  output logic        err_hdr,
  output logic        err_rx_to,
  output logic        err_add_to,
  output logic [15:0] frame_cnt
);

  logic                    w_rx_evt;
  logic                    w_tx_evt;
  state_t                  r_state;
  logic [2:0]              r_rx_idx;
  logic [2:0]              r_tx_idx;
  logic [31:0]             r_gap_cnt;
  logic [31:0]             r_wd_cnt;
  logic [31:0]             r_op_a;
  logic [31:0]             r_op_b;
  logic [1:0]              r_sel;
  logic [31:0]             r_sum;
  logic [15:0]             r_frame_cnt;
  logic                    r_err_hdr;
  logic                    r_err_rx_to;
  logic                    r_err_add_to;
  logic                    w_hdr_ok;
  logic                    w_set_hdr;
  logic                    w_gap_exp;
  logic                    w_wd_exp;
  logic [1:0]              w_byte_pos;
  logic [8*TX_BYTES-1:0]   w_tx_word;
  logic [7:0]              w_tx_byte;

  uart_fall_det u_rx_det (.clk(sys_clk), .rst_n(rst_n), .i_sig(rx_status), .o_fall(w_rx_evt));
  uart_fall_det u_tx_det (.clk(sys_clk), .rst_n(rst_n), .i_sig(tx_status), .o_fall(w_tx_evt));

  assign w_hdr_ok   = (rx_d_out[7:4] == HDR_MAGIC);
  assign w_set_hdr  = (r_state == IDLE) && w_rx_evt && !w_hdr_ok;
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_gap_exp  = (r_state == RX_OPS) && !w_rx_evt && (r_gap_cnt == 32'(RX_GAP_CYC));
  assign w_wd_exp   = (r_state == WAIT_ADD) && !add_done && (r_wd_cnt == 32'(ADD_MAX_CYC));
  assign w_byte_pos = 2'd3 - r_rx_idx[1:0];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_idx    <= '0;
      r_tx_idx    <= '0;
      r_gap_cnt   <= '0;
      r_wd_cnt    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sel       <= '0;
      r_sum       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rx_evt && w_hdr_ok) begin
            r_sel     <= rx_d_out[1:0];
            r_rx_idx  <= '0;
            r_gap_cnt <= '0;
            r_state   <= RX_OPS;
          end
        end
        RX_OPS: begin
          if (w_rx_evt) begin
            r_gap_cnt <= '0;
            if (r_rx_idx[2]) r_op_b[{w_byte_pos, 3'b000} +: 8] <= rx_d_out;
            else             r_op_a[{w_byte_pos, 3'b000} +: 8] <= rx_d_out;
            if (r_rx_idx == 3'(OP_BYTES - 1)) r_state <= LAUNCH;
            else                              r_rx_idx <= r_rx_idx + 3'd1;
          end else if (w_gap_exp) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        LAUNCH: begin
          r_wd_cnt <= '0;
          r_state  <= WAIT_ADD;
        end
        WAIT_ADD: begin
          if (add_done) begin
            r_sum    <= sum;
            r_tx_idx <= '0;
            r_state  <= TX;
          end else if (w_wd_exp) begin
            r_state <= IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
          end
        end
        TX: begin
          if (w_tx_evt) begin
            if (r_tx_idx == 3'(TX_BYTES - 1)) begin
              r_tx_idx    <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_hdr    <= 1'b0;
      r_err_rx_to  <= 1'b0;
      r_err_add_to <= 1'b0;
    end else begin
      r_err_hdr    <= w_set_hdr | (r_err_hdr    & ~err_clr);
      r_err_rx_to  <= w_gap_exp | (r_err_rx_to  & ~err_clr);
      r_err_add_to <= w_wd_exp  | (r_err_add_to & ~err_clr);
    end
  end

`ifdef ADDER_SEQ_CARRY_BYTE_EN
  logic r_cout;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                               r_cout <= 1'b0;
    else if (r_state == WAIT_ADD && add_done) r_cout <= cout;
  end

  assign w_tx_word = {r_sum, 7'b0, r_cout};
`else
  logic w_unused_cout;

  assign w_unused_cout = cout;
  assign w_tx_word     = r_sum;
`endif

  always_comb begin
    w_tx_byte = '0;
    for (int i = 0; i < TX_BYTES; i++) begin
      if (r_tx_idx == 3'(i)) w_tx_byte = w_tx_word[8*(TX_BYTES-1-i) +: 8];
    end
  end

  assign tx_en      = (r_state == TX);
  assign tx_d_in    = w_tx_byte;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign adder_sel  = r_sel;
  assign add_start  = (r_state == LAUNCH);
  assign busy       = (r_state != IDLE);
  assign err_hdr    = r_err_hdr;
  assign err_rx_to  = r_err_rx_to;
  assign err_add_to = r_err_add_to;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_adder_frame_sequencer.sv
// Randomised self-checking bench: the bench plays UART RX/TX and the adder, and predicts TX bytes from a+b.
// Build with ADDER_SEQ_CARRY_BYTE_EN defined to exercise the carry byte.
module tb_adder_frame_sequencer;
  import adder_seq_pkg::*;

  localparam int GAP = 100;
  localparam int WD  = 64;

  logic        sys_clk   = 1'b0;
  logic        rst_n     = 1'b1;
  logic        rx_status = 1'b0;
  logic [7:0]  rx_d_out  = 8'h00;
  logic        tx_status = 1'b0;
  logic        add_done  = 1'b0;
  logic [31:0] sum       = 32'h0;
  logic        cout      = 1'b0;
  logic        err_clr   = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_d_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  adder_sel;
  logic        add_start;
  logic        busy;
  logic        err_hdr;
  logic        err_rx_to;
  logic        err_add_to;
  logic [15:0] frame_cnt;

  adder_frame_sequencer #(.RX_GAP_CYC(GAP), .ADD_MAX_CYC(WD)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_status(rx_status), .rx_d_out(rx_d_out),
    .tx_status(tx_status), .tx_en(tx_en), .tx_d_in(tx_d_in), .op_a(op_a), .op_b(op_b),
    .adder_sel(adder_sel), .add_start(add_start), .add_done(add_done), .sum(sum),
    .cout(cout), .err_clr(err_clr), .busy(busy), .err_hdr(err_hdr), .err_rx_to(err_rx_to),
    .err_add_to(err_add_to), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adder stand-in
  logic        resp_en    = 1'b1;
  int          resp_delay = 3;
  logic [31:0] resp_sum   = 32'h0;
  logic        resp_cout  = 1'b0;
  int          start_cnt  = 0;
  logic [31:0] seen_a     = 32'h0;
  logic [31:0] seen_b     = 32'h0;
  logic [1:0]  seen_sel   = 2'd0;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (add_start) begin
        start_cnt++;
        seen_a   = op_a;
        seen_b   = op_b;
        seen_sel = adder_sel;
        if (resp_en) begin
          repeat (resp_delay) @(negedge sys_clk);
          sum      = resp_sum;
          cout     = resp_cout;
          add_done = 1'b1;
          @(negedge sys_clk);
          add_done = 1'b0;
        end
      end
    end
  end

  // UART transmitter stand-in
  logic [7:0] tx_q[$];
  int         tx_en_cyc = 0;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_en && !tx_status) begin
        tx_q.push_back(tx_d_in);
        tx_status = 1'b1;
        repeat (3) @(negedge sys_clk);
        tx_status = 1'b0;
        repeat (2) @(negedge sys_clk);
      end
    end
  end

  always @(negedge sys_clk) if (tx_en) tx_en_cyc++;

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_d_out  = b;
    rx_status = 1'b1;
    repeat (2) @(negedge sys_clk);
    rx_status = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ops;
    ops = {a, b};
    send_byte({4'hA, 2'b00, sel});
    for (int i = 0; i < 8; i++) send_byte(ops[63-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (busy && k < max_cyc) begin
      @(negedge sys_clk);
      k++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_tx_en(input string tag);
    int k;
    k = 0;
    while (!tx_en && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    check_eq(tag, tx_en, 1'b1);
  endtask

  int exp_frames = 0;

  task automatic run_frame(input string tag, input logic [1:0] sel, input logic [31:0] a,
                           input logic [31:0] b, input int dly, input bit inject);
    logic [32:0] full;
    logic [7:0]  exp_b[$];
    full = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < 4; i++) exp_b.push_back(full[31-8*i -: 8]);
`ifdef ADDER_SEQ_CARRY_BYTE_EN
    exp_b.push_back({7'b0, full[32]});
`endif
    tx_q.delete();
    start_cnt  = 0;
    resp_en    = 1'b1;
    resp_delay = dly;
    resp_sum   = full[31:0];
    resp_cout  = full[32];
    send_frame(sel, a, b);
    if (inject) begin
      wait_tx_en({tag, "_txen"});
      send_byte(8'h5F);
    end
    wait_idle({tag, "_idle"}, 400);
    exp_frames++;
    check_eq({tag, "_starts"}, start_cnt, 1);
    check_eq({tag, "_sel"}, seen_sel, sel);
    check_eq({tag, "_opa"}, seen_a, a);
    check_eq({tag, "_opb"}, seen_b, b);
    check_eq({tag, "_ntx"}, tx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < tx_q.size(); i++)
      check_eq($sformatf("%s_tx%0d", tag, i), tx_q[i], exp_b[i]);
    check_eq({tag, "_fcnt"}, frame_cnt, exp_frames);
    if (inject) check_eq({tag, "_nohdrerr"}, err_hdr, 1'b0);
    $display("[TB] frame %s sel=%0d a=%08h b=%08h sum=%09h bytes=%0d", tag, sel, a, b, full, tx_q.size());
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_outs", {tx_en, tx_d_in, adder_sel, add_start, busy, err_hdr, err_rx_to, err_add_to},
             '0);
    check_eq("rst_ops", {op_a, op_b}, '0);
    check_eq("rst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    run_frame("directed", 2'd1, 32'h5, 32'h7, 3, 1'b0);

    // Bad header, then recovery
    start_cnt = 0;
    send_byte(8'h5F);
    repeat (3) @(negedge sys_clk);
    check_eq("badhdr_err", err_hdr, 1'b1);
    check_eq("badhdr_busy", busy, 1'b0);
    check_eq("badhdr_starts", start_cnt, 0);
    $display("[TB] bad header 5F sent");
    run_frame("after_hdr", 2'd2, 32'h1234_5678, 32'h0101_0101, 2, 1'b0);

    // Inter-byte gap expiry
    start_cnt = 0;
    send_byte(8'hA3);
    for (int i = 0; i < 3; i++) send_byte(8'h11);
    repeat (GAP - 20) @(negedge sys_clk);
    check_eq("gap_not_yet", {busy, err_rx_to}, 2'b10);
    repeat (40) @(negedge sys_clk);
    check_eq("gap_err", err_rx_to, 1'b1);
    check_eq("gap_busy", busy, 1'b0);
    check_eq("gap_starts", start_cnt, 0);
    $display("[TB] rx gap timeout frame sent");
    run_frame("after_gap", 2'd3, 32'hDEAD_0000, 32'h0000_BEEF, 5, 1'b0);

    // Adder watchdog
    resp_en   = 1'b0;
    tx_en_cyc = 0;
    send_frame(2'd0, 32'h1, 32'h2);
    wait_idle("wd_idle", WD + 50);
    check_eq("wd_err", err_add_to, 1'b1);
    check_eq("wd_no_tx", tx_en_cyc, 0);
    check_eq("wd_fcnt", frame_cnt, exp_frames);
    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    check_eq("errclr", {err_hdr, err_rx_to, err_add_to}, 3'b000);
    $display("[TB] adder watchdog frame sent, errors cleared");

    run_frame("inject", 2'd2, 32'h0F0F_0F0F, 32'h1010_1010, 1, 1'b1);

    for (int n = 0; n < 6; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (n == 0) ? ~ra + 32'd1 : $urandom;
      run_frame($sformatf("rand%0d", n), 2'($urandom_range(0, 3)), ra, rb,
                int'($urandom_range(1, 10)), 1'b0);
    end

`ifdef ADDER_SEQ_CARRY_BYTE_EN
    run_frame("carry", 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 2, 1'b0);
`endif

    // Reset in the middle of TX
    resp_en    = 1'b1;
    resp_delay = 2;
    resp_sum   = 32'hCAFE_F00D;
    resp_cout  = 1'b1;
    send_frame(2'd3, 32'hCAFE_0000, 32'h0000_F00D);
    wait_tx_en("midtx_txen");
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check_eq("midtx_outs", {tx_en, tx_d_in, adder_sel, add_start, busy, err_hdr, err_rx_to, err_add_to},
             '0);
    check_eq("midtx_ops", {op_a, op_b}, '0);
    check_eq("midtx_fcnt", frame_cnt, 0);
    $display("[TB] reset asserted mid-TX");
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
